// File: rtl/stage4_semester.sv
// rtl/stage4_semester.sv - term tracker: consumes day results, runs TERM/PROBATION FSM, issues the term verdict
//
// Optional feature macro: STAGE4_BONUS_EN (a passed day with bonus2==2'b11 earns 2 credits)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a new term from IDLE or DONE
//   day_valid  day result present on pass3/bonus2
//   day_ready  day can be accepted (TERM or PROBATION)
//   pass3      day passed (1) / failed (0)
//   bonus2     exam bonus of the day
//   state      0=IDLE 1=TERM 2=PROBATION 3=DONE
//   day_cnt    days accepted this term
//   pass_cnt   pass credit this term, saturating at 255
//   done       high while in DONE
//   graduated  verdict, valid while done
//   expelled   verdict, valid while done
module stage4_semester #(
    parameter int DAYS         = 16,
    parameter int PASS_NEED    = 12,
    parameter int PROB_LIMIT   = 3,
    parameter int EXPEL_LIMIT  = 2,
    parameter int PROB_RECOVER = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       day_valid,
    output logic       day_ready,
    input  logic       pass3,
    input  logic [1:0] bonus2,
    output logic [1:0] state,
    output logic [7:0] day_cnt,
    output logic [7:0] pass_cnt,
    output logic       done,
    output logic       graduated,
    output logic       expelled
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TERM = 2'd1,
        S_PROB = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] DAYS_8    = 8'(DAYS);
    localparam logic [7:0] PROB_LIM8 = 8'(PROB_LIMIT);
    localparam logic [7:0] EXPEL_LIM8 = 8'(EXPEL_LIMIT);
    localparam logic [7:0] RECOVER8  = 8'(PROB_RECOVER);

    state_t     cur;
    logic [7:0] fail_streak;
    logic [7:0] prob_fail;
    logic [7:0] pass_streak;

    logic       accept;
    logic [1:0] credit;
    logic [8:0] pass_sum;
    logic [7:0] pass_next;
    logic [7:0] day_next;
    logic [7:0] fail_streak_inc;
    logic [7:0] prob_fail_inc;
    logic [7:0] pass_streak_inc;
    logic       expel_now;
    logic       term_end;
    logic       to_prob;
    logic       to_term;

    assign state     = cur;
    assign day_ready = (cur == S_TERM) || (cur == S_PROB);
    assign done      = (cur == S_DONE);
    assign accept    = day_valid && day_ready;

`ifdef STAGE4_BONUS_EN
    always_comb begin
        credit = 2'd0;
        if (pass3) begin
            credit = (bonus2 == 2'b11) ? 2'd2 : 2'd1;
        end
    end
`else
    logic unused_bonus;
    assign unused_bonus = ^bonus2;

    always_comb begin
        credit = pass3 ? 2'd1 : 2'd0;
    end
`endif

    always_comb begin
        pass_sum        = {1'b0, pass_cnt} + {7'd0, credit};
        pass_next       = pass_sum[8] ? 8'hFF : pass_sum[7:0];
        // day_cnt never exceeds DAYS (<=255) because reaching it ends the term
        day_next        = day_cnt + 8'd1;
        fail_streak_inc = (fail_streak >= PROB_LIM8)  ? fail_streak : fail_streak + 8'd1;
        prob_fail_inc   = (prob_fail   >= EXPEL_LIM8) ? prob_fail   : prob_fail   + 8'd1;
        pass_streak_inc = (pass_streak >= RECOVER8)   ? pass_streak : pass_streak + 8'd1;
        expel_now       = (cur == S_PROB) && !pass3 && (prob_fail_inc == EXPEL_LIM8);
        term_end        = (day_next == DAYS_8);
        to_prob         = (cur == S_TERM) && !pass3 && (fail_streak_inc == PROB_LIM8);
        to_term         = (cur == S_PROB) && pass3 && (pass_streak_inc == RECOVER8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= S_IDLE;
            day_cnt     <= 8'd0;
            pass_cnt    <= 8'd0;
            fail_streak <= 8'd0;
            prob_fail   <= 8'd0;
            pass_streak <= 8'd0;
            graduated   <= 1'b0;
            expelled    <= 1'b0;
        end else begin
            case (cur)
                S_IDLE: begin
                    if (start) begin
                        cur <= S_TERM;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        cur         <= S_TERM;
                        day_cnt     <= 8'd0;
                        pass_cnt    <= 8'd0;
                        fail_streak <= 8'd0;
                        prob_fail   <= 8'd0;
                        pass_streak <= 8'd0;
                        graduated   <= 1'b0;
                        expelled    <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        day_cnt  <= day_next;
                        pass_cnt <= pass_next;

                        // Priority: expulsion, then term end, then TERM<->PROBATION moves
                        if (expel_now) begin
                            cur       <= S_DONE;
                            expelled  <= 1'b1;
                            graduated <= 1'b0;
                        end else if (term_end) begin
                            cur       <= S_DONE;
                            graduated <= ({24'd0, pass_next} >= 32'(PASS_NEED));
                            expelled  <= 1'b0;
                        end else if (to_prob) begin
                            cur <= S_PROB;
                        end else if (to_term) begin
                            cur <= S_TERM;
                        end

                        if (cur == S_TERM) begin
                            if (pass3) begin
                                fail_streak <= 8'd0;
                            end else begin
                                fail_streak <= fail_streak_inc;
                                if (to_prob) begin
                                    prob_fail   <= 8'd0;
                                    pass_streak <= 8'd0;
                                end
                            end
                        end else begin
                            if (pass3) begin
                                pass_streak <= pass_streak_inc;
                                if (to_term) begin
                                    fail_streak <= 8'd0;
                                end
                            end else begin
                                prob_fail   <= prob_fail_inc;
                                pass_streak <= 8'd0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage4_semester.sv
// tb/tb_stage4_semester.sv - self-checking bench for stage4_semester against a term-rules model
module tb_stage4_semester;

    localparam int DAYS         = 16;
    localparam int PASS_NEED    = 12;
    localparam int PROB_LIMIT   = 3;
    localparam int EXPEL_LIMIT  = 2;
    localparam int PROB_RECOVER = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       day_valid = 1'b0;
    logic       day_ready;
    logic       pass3 = 1'b0;
    logic [1:0] bonus2 = 2'd0;
    logic [1:0] state;
    logic [7:0] day_cnt;
    logic [7:0] pass_cnt;
    logic       done;
    logic       graduated;
    logic       expelled;

    stage4_semester #(
        .DAYS(DAYS), .PASS_NEED(PASS_NEED), .PROB_LIMIT(PROB_LIMIT),
        .EXPEL_LIMIT(EXPEL_LIMIT), .PROB_RECOVER(PROB_RECOVER)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .day_valid(day_valid),
        .day_ready(day_ready), .pass3(pass3), .bonus2(bonus2), .state(state),
        .day_cnt(day_cnt), .pass_cnt(pass_cnt), .done(done),
        .graduated(graduated), .expelled(expelled)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model of the term, kept as plain integers
    int m_state = 0;
    int m_day = 0;
    int m_pass = 0;
    int m_fails_in_row = 0;
    int m_prob_fails = 0;
    int m_pass_in_row = 0;
    int m_grad = 0;
    int m_expel = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_day = 0; m_pass = 0; m_fails_in_row = 0; m_prob_fails = 0;
        m_pass_in_row = 0; m_grad = 0; m_expel = 0;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit v, input bit p, input int b);
        int credit;
        int nxt;
        if (r) begin
            m_state = 0;
            model_clear();
        end else if (m_state == 0 || m_state == 3) begin
            if (s) begin
                m_state = 1;
                model_clear();
            end
        end else if (v) begin
            credit = p ? 1 : 0;
`ifdef STAGE4_BONUS_EN
            if (p && b == 3) credit = 2;
`endif
            m_day++;
            m_pass = (m_pass + credit > 255) ? 255 : m_pass + credit;
            nxt = m_state;
            if (m_state == 1) begin
                if (p) m_fails_in_row = 0;
                else begin
                    m_fails_in_row++;
                    if (m_fails_in_row >= PROB_LIMIT) begin
                        nxt = 2; m_prob_fails = 0; m_pass_in_row = 0;
                    end
                end
            end else begin
                if (p) begin
                    m_pass_in_row++;
                    if (m_pass_in_row >= PROB_RECOVER) begin
                        nxt = 1; m_fails_in_row = 0;
                    end
                end else begin
                    m_prob_fails++;
                    m_pass_in_row = 0;
                    if (m_prob_fails >= EXPEL_LIMIT) nxt = 4;
                end
            end
            if (nxt == 4) begin
                m_state = 3; m_expel = 1; m_grad = 0;
            end else if (m_day == DAYS) begin
                m_state = 3; m_expel = 0; m_grad = (m_pass >= PASS_NEED) ? 1 : 0;
            end else begin
                m_state = nxt;
            end
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit v, input bit p, input logic [1:0] b);
        @(negedge clk);
        rst = r; start = s; day_valid = v; pass3 = p; bonus2 = b;
        @(posedge clk);
        model_edge(r, s, v, p, int'(b));
        #1;
    endtask

    task automatic new_term();
        tick(1, 0, 0, 0, 2'd0);
        tick(0, 1, 0, 0, 2'd0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", int'(state), m_state);
            chk("day_ready", int'(day_ready), (m_state == 1 || m_state == 2) ? 1 : 0);
            chk("day_cnt", int'(day_cnt), m_day);
            chk("pass_cnt", int'(pass_cnt), m_pass);
            chk("done", int'(done), (m_state == 3) ? 1 : 0);
            chk("graduated", int'(graduated), m_grad);
            chk("expelled", int'(expelled), m_expel);
        end
    end

    initial begin
        // Reset held two cycles with day_valid high
        tick(1, 0, 1, 1, 2'd0);
        chk_en = 1'b1;
        tick(1, 0, 1, 1, 2'd0);
        chk("rst_state", int'(state), 0);
        chk("rst_ready", int'(day_ready), 0);
        chk("rst_day", int'(day_cnt), 0);
        chk("rst_pass", int'(pass_cnt), 0);
        chk("rst_flags", int'({done, graduated, expelled}), 0);

        // Clean term of 16 passes, then an ignored 17th day
        new_term();
        for (int i = 0; i < 16; i++) tick(0, 0, 1, 1, 2'd0);
        chk("clean_state", int'(state), 3);
        chk("clean_day", int'(day_cnt), 16);
        chk("clean_pass", int'(pass_cnt), 16);
        chk("clean_grad", int'(graduated), 1);
        chk("clean_expel", int'(expelled), 0);
        chk("clean_ready", int'(day_ready), 0);
        tick(0, 0, 1, 1, 2'd0);
        chk("clean_17th", int'(day_cnt), 16);

        // Probation and recovery
        new_term();
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 2'd0);
        chk("prob_state", int'(state), 2);
        tick(0, 0, 1, 1, 2'd0);
        tick(0, 0, 1, 1, 2'd0);
        chk("recover_state", int'(state), 1);
        chk("recover_pass", int'(pass_cnt), 2);
        chk("recover_day", int'(day_cnt), 5);

        // Expulsion, then a fresh start
        new_term();
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 2'd0);
        chk("expel_state", int'(state), 3);
        chk("expel_flag", int'(expelled), 1);
        chk("expel_grad", int'(graduated), 0);
        chk("expel_day", int'(day_cnt), 5);
        tick(0, 1, 0, 0, 2'd0);
        chk("restart_state", int'(state), 1);
        chk("restart_cnts", int'({day_cnt, pass_cnt}), 0);
        chk("restart_expel", int'(expelled), 0);

        // Third fail lands on day 16: term end wins over probation
        new_term();
        for (int i = 0; i < 13; i++) tick(0, 0, 1, 1, 2'd0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 2'd0);
        chk("bound_state", int'(state), 3);
        chk("bound_pass", int'(pass_cnt), 13);
        chk("bound_grad", int'(graduated), 1);

        // start mid-term ignored, reset mid-term clears
        new_term();
        for (int i = 0; i < 7; i++) tick(0, 0, 1, 1, 2'd0);
        tick(0, 1, 0, 0, 2'd0);
        chk("mid_start_state", int'(state), 1);
        chk("mid_start_day", int'(day_cnt), 7);
        tick(1, 0, 1, 1, 2'd0);
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_cnts", int'({day_cnt, pass_cnt}), 0);

        // Bonus credit on alternating P,F days
        new_term();
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, 1, 2'd3);
            tick(0, 0, 1, 0, 2'd3);
        end
        chk("bonus_state", int'(state), 3);
`ifdef STAGE4_BONUS_EN
        chk("bonus_pass", int'(pass_cnt), 16);
        chk("bonus_grad", int'(graduated), 1);
`else
        chk("bonus_pass", int'(pass_cnt), 8);
        chk("bonus_grad", int'(graduated), 0);
`endif

        // Randomized traffic with a pass bias that drifts per segment
        new_term();
        for (int seg = 0; seg < 20; seg++) begin
            int bias;
            bias = $urandom_range(1, 3);
            for (int i = 0; i < 150; i++) begin
                tick(($urandom % 250) == 0, ($urandom % 6) == 0, ($urandom % 3) != 0,
                     ($urandom % 4) < bias, 2'($urandom % 4));
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stage4_semester.md
Name: stage4_semester

Overview:
- Downstream consumer of the day pipeline (commute -> exam -> presentation). Accepts one day result per handshake: the final pass3 and the exam bonus2.
- Tracks a full term of days through a state machine with consecutive-fail probation and expulsion.
- Produces the term verdict (graduated or expelled) plus running counters for display and scoring.

Parameters:
- DAYS, 16, term length in accepted days (1..255).
- PASS_NEED, 12, passed-day credit required to graduate at term end.
- PROB_LIMIT, 3, consecutive failed days in TERM that trigger PROBATION (>=1).
- EXPEL_LIMIT, 2, failed days (not necessarily consecutive) while in PROBATION that cause expulsion (>=1).
- PROB_RECOVER, 2, consecutive passed days in PROBATION that return the block to TERM (>=1).

Ports:
- clk  input  1  clock, all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begins a new term from IDLE or DONE.
- day_valid  input  1  a day result is presented on pass3/bonus2.
- day_ready  output  1  block can accept a day; high only in TERM or PROBATION.
- pass3  input  1  day passed (1) / failed (0).
- bonus2  input  2  exam bonus of that day; used only with the optional feature.
- state  output  2  0=IDLE, 1=TERM, 2=PROBATION, 3=DONE.
- day_cnt  output  8  days accepted this term.
- pass_cnt  output  8  pass credit this term, saturating at 255.
- done  output  1  level, high while in DONE.
- graduated  output  1  valid when done=1.
- expelled  output  1  valid when done=1; never high together with graduated.

Behaviour:
- Reset (rst=1 at edge, highest priority, including mid-term):
  - state=IDLE.
  - All counters, fail_streak, prob_fail, pass_streak=0.
  - done, graduated, expelled=0; day_ready=0.
- Accept condition: day_valid & day_ready at a rising edge. day_valid while day_ready=0 is ignored, no side effects. One day accepted per cycle max. day_ready is a registered-state decode (combinational from state only, no dependency on day_valid).
- IDLE: start=1 -> TERM. Counters already zero.
- DONE: done=1, verdict held. start=1 -> TERM; clear day_cnt, pass_cnt, streaks, graduated, expelled in the same edge.
- start in TERM/PROBATION is ignored.
- Every accepted day increments day_cnt.
- TERM, accepted pass:
  - pass_cnt += credit; fail_streak=0.
- TERM, accepted fail:
  - fail_streak += 1.
  - If the new fail_streak == PROB_LIMIT -> PROBATION; clear prob_fail and pass_streak.
- PROBATION, accepted pass:
  - pass_cnt += credit; pass_streak += 1.
  - If pass_streak reaches PROB_RECOVER -> TERM; clear fail_streak.
- PROBATION, accepted fail:
  - prob_fail += 1; pass_streak=0.
  - If prob_fail reaches EXPEL_LIMIT -> DONE, expelled=1, graduated=0.
- Term end: if the accepted day makes day_cnt == DAYS and expulsion did not occur on that day:
  - -> DONE.
  - graduated = (updated pass_cnt >= PASS_NEED); expelled=0.
- Simultaneous events:
  - Expulsion beats term end.
  - Term end beats the TERM<->PROBATION transition, which is then discarded.
- All outputs update one cycle after the accepting edge, with no extra pipeline latency.
- Widths:
  - Counters are 8-bit. pass_cnt saturates at 255.
  - Streak counters saturate at their limit.
  - Comparisons are unsigned.
- Default credit per passed day = 1.

Optional Feature:
- Macro: STAGE4_BONUS_EN.
- Defined: a passed day with bonus2==2'b11 credits 2 to pass_cnt (saturating); any other bonus2 credits 1. Failed days credit 0 regardless of bonus2.
- Undefined: bonus2 port stays present but is ignored; credit is always 1.

Test Plan:
- Reset: rst=1 for 2 cycles with day_valid=1 -> state=0, day_ready=0, day_cnt=0, pass_cnt=0, done/graduated/expelled=0.
- Clean term:
  - Stimulus: start, then 16 accepted passes, bonus2=0.
  - Required: state=3 after the 16th, day_cnt=16, pass_cnt=16, graduated=1, expelled=0, day_ready=0.
  - A 17th day_valid is ignored.
- Probation and recovery:
  - Stimulus: start, then F,F,F.
  - Required: state=2 after the 3rd fail.
  - Then P,P -> state=1, pass_cnt=2, day_cnt=5.
- Expulsion:
  - Stimulus: start, then F,F,F,F,F.
  - Required: state=3, expelled=1, graduated=0, day_cnt=5.
  - A following start -> state=1, all counters 0, expelled=0.
- Term end on the boundary:
  - Stimulus: start, then 13 P followed by F,F,F (the 3rd fail is day 16).
  - Required: state=3 (not 2), pass_cnt=13, graduated=1.
  - Separately: start mid-term is ignored; rst mid-term (day_cnt=7) -> state=0, counters 0.
- Bonus:
  - Stimulus: start, then 8 P with bonus2=3 and 8 F interleaved as P,F.
  - With STAGE4_BONUS_EN: pass_cnt=16, graduated=1.
  - Without it: pass_cnt=8, graduated=0.
